cell_board_engine: RTL and testbench

//  Owns the Game-of-Life board memory and computes each next generation.
//  Its combinational read port answers the display controller's cell_x/cell_y

---
 rtl/cell_board_engine_if.sv | 32 +++
 rtl/cell_board_engine.sv | 140 ++++++++++++++
 tb/tb_cell_board_engine.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_board_engine_if.sv
// Bus between the display/controller side and the Game-of-Life board engine.
// The controller (master) raises requests and drives the cursor and display
// read coordinates; the engine (slave) answers with cell state and status.
interface cell_board_engine_if #(
  parameter int ADDR_W = 8,
  parameter int GEN_W  = 16
);
  logic              mode;
  logic              step_req;
  logic              clear_req;
  logic              edit_toggle;
  logic [ADDR_W-1:0] cur_x;
  logic [ADDR_W-1:0] cur_y;
  logic [ADDR_W-1:0] cell_x;
  logic [ADDR_W-1:0] cell_y;
  logic              cell_state;
  logic              busy;
  logic              gen_done;
  logic [GEN_W-1:0]  gen_count;

  modport master (
    output mode, step_req, clear_req, edit_toggle,
    output cur_x, cur_y, cell_x, cell_y,
    input  cell_state, busy, gen_done, gen_count
  );

  modport slave (
    input  mode, step_req, clear_req, edit_toggle,
    input  cur_x, cur_y, cell_x, cell_y,
    output cell_state, busy, gen_done, gen_count
  );
endinterface

// File: rtl/cell_board_engine.sv
// Game-of-Life board engine: two bit-planes, one displayed (active) and one
// receiving the next generation (shadow). A one-cycle swap commits a whole
// generation at once so the display never shows a half-computed board.
//
//  state | meaning
//  IDLE  | accept clear / step / edit toggle, board static
//  SCAN  | one cell per cycle, next state written to the shadow plane
//  SWAP  | flip active plane, bump generation count, pulse gen_done
module cell_board_engine #(
  parameter int BOARD_W = 32,
  parameter int BOARD_H = 32,
  parameter int ADDR_W  = 8,
  parameter int GEN_W   = 16
) (
  input logic                 clk,
  input logic                 rst,
  cell_board_engine_if.slave  bus
);

  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);

  // Mode encoding shared with the display controller.
  localparam logic MODE_EDIT = 1'b1;

  localparam logic [ADDR_W-1:0] W_LIM  = ADDR_W'(BOARD_W);
  localparam logic [ADDR_W-1:0] H_LIM  = ADDR_W'(BOARD_H);
  localparam logic [XW-1:0]     X_LAST = XW'(BOARD_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(BOARD_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SWAP = 2'd2
  } state_t;

  logic [BOARD_W-1:0] plane [2][BOARD_H];

  state_t           state;
  logic             act;
  logic [XW-1:0]    sx;
  logic [YW-1:0]    sy;
  logic             busy_q;
  logic             gen_done_q;
  logic [GEN_W-1:0] gen_q;

  logic [XW-1:0]      xm, xp;
  logic [YW-1:0]      ym, yp;
  logic [BOARD_W-1:0] row_m, row_c, row_p;
  logic [3:0]         nbr;
  logic               nxt;
  logic               rd_in_range;
  logic               cur_in_range;
  logic [XW-1:0]      rd_x, cur_cx;
  logic [YW-1:0]      rd_y, cur_cy;

  // Toroidal neighbourhood of the scan cell and its next state.
  always_comb begin
    xm    = (sx == '0)     ? X_LAST : sx - XW'(1);
    xp    = (sx == X_LAST) ? '0     : sx + XW'(1);
    ym    = (sy == '0)     ? Y_LAST : sy - YW'(1);
    yp    = (sy == Y_LAST) ? '0     : sy + YW'(1);
    row_m = plane[act][ym];
    row_c = plane[act][sy];
    row_p = plane[act][yp];
    nbr   = {3'b000, row_m[xm]} + {3'b000, row_m[sx]} + {3'b000, row_m[xp]} +
            {3'b000, row_c[xm]}                       + {3'b000, row_c[xp]} +
            {3'b000, row_p[xm]} + {3'b000, row_p[sx]} + {3'b000, row_p[xp]};
    nxt   = (nbr == 4'd3) || (row_c[sx] && (nbr == 4'd2));
  end

  // Coordinate range checks and narrowed indices for read port and cursor.
  always_comb begin
    rd_in_range  = (bus.cell_x < W_LIM) && (bus.cell_y < H_LIM);
    cur_in_range = (bus.cur_x < W_LIM) && (bus.cur_y < H_LIM);
    rd_x         = bus.cell_x[XW-1:0];
    rd_y         = bus.cell_y[YW-1:0];
    cur_cx       = bus.cur_x[XW-1:0];
    cur_cy       = bus.cur_y[YW-1:0];
  end

  // Sequencer plus both board planes; reset and clear wipe everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      act        <= 1'b0;
      sx         <= '0;
      sy         <= '0;
      busy_q     <= 1'b0;
      gen_done_q <= 1'b0;
      gen_q      <= '0;
      for (int p = 0; p < 2; p++)
        for (int r = 0; r < BOARD_H; r++)
          plane[p][r] <= '0;
    end else begin
      gen_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear_req) begin
            for (int p = 0; p < 2; p++)
              for (int r = 0; r < BOARD_H; r++)
                plane[p][r] <= '0;
          end else if (bus.step_req && (bus.mode != MODE_EDIT)) begin
            state  <= SCAN;
            sx     <= '0;
            sy     <= '0;
            busy_q <= 1'b1;
          end else if (bus.edit_toggle && (bus.mode == MODE_EDIT) && cur_in_range) begin
            plane[act][cur_cy][cur_cx] <= ~plane[act][cur_cy][cur_cx];
          end
        end
        SCAN: begin
          plane[~act][sy][sx] <= nxt;
          if (sx == X_LAST) begin
            sx <= '0;
            if (sy == Y_LAST) state <= SWAP;
            else              sy    <= sy + YW'(1);
          end else begin
            sx <= sx + XW'(1);
          end
        end
        SWAP: begin
          act        <= ~act;
          gen_q      <= gen_q + GEN_W'(1);
          gen_done_q <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display read of the active plane, zero outside the board.
  assign bus.cell_state = rd_in_range ? plane[act][rd_y][rd_x] : 1'b0;
  assign bus.busy       = busy_q;
  assign bus.gen_done   = gen_done_q;
  assign bus.gen_count  = gen_q;

endmodule

// File: tb/tb_cell_board_engine.sv
// Bench for the board engine: a reference Life model predicts each
// generation, predictions are queued on step issue and popped on gen_done.
module tb_cell_board_engine;

  localparam logic MODE_EDIT = 1'b1;
  localparam logic MODE_RUN  = 1'b0;

  typedef struct packed {
    logic [15:0]   gen;
    logic [1023:0] board;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cell_board_engine_if #(.ADDR_W(8), .GEN_W(16)) bus ();

  cell_board_engine #(
    .BOARD_W(32), .BOARD_H(32), .ADDR_W(8), .GEN_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int            errs   = 0;
  int            checks = 0;
  exp_t          sb_q[$];
  logic [1023:0] mb     = '0;
  logic [15:0]   gen_m  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] life_next(input logic [1023:0] b);
    logic [1023:0] n;
    int nb;
    n = '0;
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 32; x++) begin
        nb = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0)
              nb += int'(b[((y + dy + 32) % 32) * 32 + ((x + dx + 32) % 32)]);
        n[y*32 + x] = (nb == 3) || (b[y*32 + x] && nb == 2);
      end
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int x, input int y, output logic v);
    bus.cell_x = 8'(x);
    bus.cell_y = 8'(y);
    #1;
    v = bus.cell_state;
  endtask

  task automatic cmp_board(input string tag, input logic [1023:0] exp);
    logic [31:0] row;
    logic v;
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 32; x++) begin
        rd(x, y, v);
        row[x] = v;
      end
      chk($sformatf("%s_row%0d", tag, y), row, exp[y*32 +: 32]);
    end
  endtask

  task automatic toggle(input int x, input int y, input logic md);
    bus.mode        = md;
    bus.cur_x       = 8'(x);
    bus.cur_y       = 8'(y);
    bus.edit_toggle = 1'b1;
    tick();
    bus.edit_toggle = 1'b0;
    if (md == MODE_EDIT && x < 32 && y < 32) mb[y*32 + x] = ~mb[y*32 + x];
  endtask

  task automatic do_clear();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    mb = '0;
  endtask

  // One generation; disturb injects a toggle and a step while the engine is busy.
  task automatic do_step(input string tag, input bit disturb);
    exp_t e;
    int busy_n;
    bit seen;
    mb    = life_next(mb);
    gen_m = gen_m + 16'd1;
    sb_q.push_back('{gen: gen_m, board: mb});
    bus.mode     = MODE_RUN;
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    busy_n = 0;
    seen   = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (bus.gen_done) seen = 1;
      else if (bus.busy) busy_n++;
      if (disturb) begin
        if (c == 100) begin
          bus.mode = MODE_EDIT; bus.cur_x = 8'd3; bus.cur_y = 8'd3; bus.edit_toggle = 1'b1;
        end else if (c == 101) begin
          bus.edit_toggle = 1'b0; bus.mode = MODE_RUN; bus.step_req = 1'b1;
        end else if (c == 102) begin
          bus.step_req = 1'b0;
        end
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd1025);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_gen_count"}, 32'(bus.gen_count), 32'(e.gen));
      cmp_board(tag, e.board);
    end
    @(negedge clk);
    chk({tag, "_gen_done_pulse"}, 32'(bus.gen_done), 32'd0);
  endtask

  initial begin
    logic v;
    int cnt;
    bus.mode = MODE_RUN; bus.step_req = 0; bus.clear_req = 0; bus.edit_toggle = 0;
    bus.cur_x = 0; bus.cur_y = 0; bus.cell_x = 0; bus.cell_y = 0;

    // reset held two cycles
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_gen_done", 32'(bus.gen_done), 32'd0);
    chk("rst_gen_count", 32'(bus.gen_count), 32'd0);
    rd(0, 0, v);    chk("rst_cell_0_0", 32'(v), 32'd0);
    rd(31, 31, v);  chk("rst_cell_31_31", 32'(v), 32'd0);
    rd(200, 7, v);  chk("rst_cell_200_7", 32'(v), 32'd0);
    rst = 1'b1;
    tick();

    // blinker
    toggle(5, 4, MODE_EDIT);
    toggle(5, 5, MODE_EDIT);
    toggle(5, 6, MODE_EDIT);
    cmp_board("blinker_init", mb);
    do_step("blinker", 0);
    rd(4, 5, v); chk("blinker_4_5", 32'(v), 32'd1);
    rd(5, 4, v); chk("blinker_5_4", 32'(v), 32'd0);
    rd(5, 6, v); chk("blinker_5_6", 32'(v), 32'd0);

    // edit toggles at the origin and an out-of-range cursor
    toggle(0, 0, MODE_EDIT);
    rd(0, 0, v); chk("edit_on", 32'(v), 32'd1);
    toggle(0, 0, MODE_EDIT);
    rd(0, 0, v); chk("edit_off", 32'(v), 32'd0);
    toggle(40, 0, MODE_EDIT);
    cmp_board("edit_oob", mb);
    rd(40, 0, v); chk("read_oob", 32'(v), 32'd0);

    // requests while busy, then a run-mode toggle
    do_step("busy_drop", 1);
    toggle(7, 7, MODE_RUN);
    cmp_board("run_toggle", mb);
    chk("run_toggle_gen", 32'(bus.gen_count), 32'd2);

    // glider across the wrap seam
    rst = 1'b0; tick(); tick(); rst = 1'b1;
    mb = '0; gen_m = '0;
    toggle(30, 30, MODE_EDIT);
    toggle(31, 31, MODE_EDIT);
    toggle(29, 0, MODE_EDIT);
    toggle(30, 0, MODE_EDIT);
    toggle(31, 0, MODE_EDIT);
    for (int g = 0; g < 4; g++) do_step($sformatf("glider%0d", g), 0);
    rd(31, 31, v); chk("glider_31_31", 32'(v), 32'd1);
    rd(0, 0, v);   chk("glider_0_0", 32'(v), 32'd1);
    rd(30, 1, v);  chk("glider_30_1", 32'(v), 32'd1);
    rd(31, 1, v);  chk("glider_31_1", 32'(v), 32'd1);
    rd(0, 1, v);   chk("glider_0_1", 32'(v), 32'd1);
    chk("glider_live", 32'($countones(mb)), 32'd5);
    chk("glider_gen", 32'(bus.gen_count), 32'd4);

    // clear beats step in the same cycle
    bus.mode = MODE_RUN; bus.clear_req = 1'b1; bus.step_req = 1'b1;
    tick();
    bus.clear_req = 1'b0; bus.step_req = 1'b0;
    mb = '0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    chk("clr_step_busy", 32'(cnt), 32'd0);
    cmp_board("clr_step", mb);
    chk("clr_step_gen", 32'(bus.gen_count), 32'd4);

    // reset in the middle of a scan
    toggle(10, 9, MODE_EDIT);
    toggle(10, 10, MODE_EDIT);
    toggle(10, 11, MODE_EDIT);
    bus.mode = MODE_RUN; bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mb = '0; gen_m = '0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_gen_done", 32'(bus.gen_done), 32'd0);
    chk("abort_gen_count", 32'(bus.gen_count), 32'd0);
    cmp_board("abort", mb);
    cnt = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (bus.gen_done || bus.busy) cnt++;
    end
    chk("abort_quiet", 32'(cnt), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
